// File: rtl/joyencoder.sv
// Serial joystick responder: emulates a 16-bit PISO shift register clocked by a host decoder.
// Define JOYENC_DEBOUNCE_EN to add per-button debounce counters ahead of the load word.
module joyencoder #(
    parameter int          SYNC_STAGES     = 2,
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic clk,
    input  logic rst,
    input  logic joy_clk,
    input  logic joy_load_n,
    input  logic joy1up,
    input  logic joy1down,
    input  logic joy1left,
    input  logic joy1right,
    input  logic joy1fire1,
    input  logic joy1fire2,
    input  logic joy2up,
    input  logic joy2down,
    input  logic joy2left,
    input  logic joy2right,
    input  logic joy2fire1,
    input  logic joy2fire2,
    output logic joy_data,
    output logic frame_strobe
);

    logic [SYNC_STAGES-1:0]       jclk_sync;
    logic [SYNC_STAGES-1:0]       load_sync;
    logic [SYNC_STAGES-1:0][11:0] btn_sync;
    logic                         jclk_prev;
    logic                         load_prev;
    logic                         jclk_s;
    logic                         load_s;
    logic                         jclk_rise;
    logic [11:0]                  btn_raw;
    logic [11:0]                  btn;
    logic [15:0]                  ld;
    logic [15:0]                  sr;
    logic [4:0]                   cnt;

    assign btn_raw = {joy2up, joy2down, joy2left, joy2right, joy2fire1, joy2fire2,
                      joy1up, joy1down, joy1left, joy1right, joy1fire1, joy1fire2};

    assign jclk_s    = jclk_sync[SYNC_STAGES-1];
    assign load_s    = load_sync[SYNC_STAGES-1];
    assign jclk_rise = jclk_s & ~jclk_prev;

    // Synchronizers; the extra prev flops give edge history after the last stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            jclk_sync <= '0;
            load_sync <= '1;
            btn_sync  <= '1;
            jclk_prev <= 1'b0;
            load_prev <= 1'b1;
        end else begin
            jclk_sync <= {jclk_sync[SYNC_STAGES-2:0], joy_clk};
            load_sync <= {load_sync[SYNC_STAGES-2:0], joy_load_n};
            btn_sync  <= {btn_sync[SYNC_STAGES-2:0], btn_raw};
            jclk_prev <= jclk_s;
            load_prev <= load_s;
        end
    end

`ifdef JOYENC_DEBOUNCE_EN
    logic [15:0] db_cnt [12];
    logic [11:0] db_val;

    // A button only changes after disagreeing for DEBOUNCE_CYCLES straight cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_val <= '1;
            for (int i = 0; i < 12; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 12; i++) begin
                if (btn_sync[SYNC_STAGES-1][i] == db_val[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] >= DEBOUNCE_CYCLES - 16'd1) begin
                    db_val[i] <= btn_sync[SYNC_STAGES-1][i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 16'd1;
                end
            end
        end
    end

    assign btn = db_val;
`else
    assign btn = btn_sync[SYNC_STAGES-1];
`endif

    assign ld = {btn[11:6], 2'b11, btn[5:0], 2'b11};

    // Load dominates shifting; vacated bits fill with ones so an over-clocked frame reads released
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr           <= 16'hFFFF;
            cnt          <= 5'd0;
            frame_strobe <= 1'b0;
        end else begin
            frame_strobe <= load_s & ~load_prev;
            if (!load_s) begin
                sr  <= ld;
                cnt <= 5'd0;
            end else if (jclk_rise) begin
                sr <= {1'b1, sr[15:1]};
                if (cnt != 5'd16) cnt <= cnt + 5'd1;
            end
        end
    end

    assign joy_data = sr[0];

endmodule

// File: tb/tb_joyencoder.sv
// Directed bench for joyencoder: frames are driven like the host decoder and read back serially.
module tb_joyencoder;

    logic clk = 1'b0;
    logic rst;
    logic joy_clk;
    logic joy_load_n;
    logic joy1up, joy1down, joy1left, joy1right, joy1fire1, joy1fire2;
    logic joy2up, joy2down, joy2left, joy2right, joy2fire1, joy2fire2;
    logic joy_data;
    logic frame_strobe;

    int checks = 0;
    int errors = 0;

    joyencoder #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(16'd8)) dut (
        .clk(clk), .rst(rst), .joy_clk(joy_clk), .joy_load_n(joy_load_n),
        .joy1up(joy1up), .joy1down(joy1down), .joy1left(joy1left),
        .joy1right(joy1right), .joy1fire1(joy1fire1), .joy1fire2(joy1fire2),
        .joy2up(joy2up), .joy2down(joy2down), .joy2left(joy2left),
        .joy2right(joy2right), .joy2fire1(joy2fire1), .joy2fire2(joy2fire2),
        .joy_data(joy_data), .frame_strobe(frame_strobe)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic release_all();
        {joy1up, joy1down, joy1left, joy1right, joy1fire1, joy1fire2} = 6'h3F;
        {joy2up, joy2down, joy2left, joy2right, joy2fire1, joy2fire2} = 6'h3F;
    endtask

    task automatic pulse_load();
        joy_load_n = 1'b0;
        tick(8);
        joy_load_n = 1'b1;
        tick(8);
    endtask

    // Bit k is taken while joy_clk is low, just before its k-th rising edge
    task automatic read_bits(input int n, output logic [31:0] word);
        word = '1;
        for (int k = 0; k < n; k++) begin
            word[k] = joy_data;
            joy_clk = 1'b1;
            tick(8);
            joy_clk = 1'b0;
            tick(8);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; joy_clk = 1'b0; joy_load_n = 1'b1;
        release_all();
        tick(3);
        checks++;
        if (joy_data !== 1'b1) begin
            errors++; $display("FAIL reset_joy_data got %b want 1", joy_data);
        end
        checks++;
        if (frame_strobe !== 1'b0) begin
            errors++; $display("FAIL reset_strobe got %b want 0", frame_strobe);
        end
        checks++;
        if (dut.cnt !== 5'd0) begin
            errors++; $display("FAIL reset_cnt got %0d want 0", dut.cnt);
        end
        rst = 1'b0;
        tick(2);
    endtask

    task automatic test_idle();
        int bad = 0;
        for (int p = 0; p < 10; p++) begin
            joy_clk = ~joy_clk;
            for (int t = 0; t < 8; t++) begin
                tick(1);
                checks++;
                if (joy_data !== 1'b1 || frame_strobe !== 1'b0) begin
                    errors++; bad++;
                    if (bad < 4)
                        $display("FAIL idle data=%b strobe=%b want data=1 strobe=0", joy_data, frame_strobe);
                end
            end
        end
        joy_clk = 1'b0;
        tick(4);
    endtask

    task automatic test_frame();
        logic [31:0] w;
        joy1up = 1'b0; joy2fire2 = 1'b0;
        tick(4);
        joy_load_n = 1'b0;
        tick(8);
        joy_load_n = 1'b1;
        tick(2);
        checks++;
        if (frame_strobe !== 1'b0) begin
            errors++; $display("FAIL strobe_early got %b want 0", frame_strobe);
        end
        tick(1);
        checks++;
        if (frame_strobe !== 1'b1) begin
            errors++; $display("FAIL strobe_pulse got %b want 1", frame_strobe);
        end
        tick(1);
        checks++;
        if (frame_strobe !== 1'b0) begin
            errors++; $display("FAIL strobe_width got %b want 0", frame_strobe);
        end
        tick(4);
        read_bits(16, w);
        checks++;
        if (w[15:0] !== 16'hFB7F) begin
            errors++; $display("FAIL frame_word got %h want fb7f", w[15:0]);
        end
        release_all();
        tick(4);
    endtask

    task automatic test_shift_latency();
        logic [31:0] w;
        joy1fire2 = 1'b0;
        tick(4);
        pulse_load();
        read_bits(1, w);
        joy_clk = 1'b1;
        tick(2);
        checks++;
        if (joy_data !== 1'b1) begin
            errors++; $display("FAIL latency_early got %b want 1", joy_data);
        end
        tick(1);
        checks++;
        if (joy_data !== 1'b0) begin
            errors++; $display("FAIL latency_bit2 got %b want 0", joy_data);
        end
        tick(5);
        joy_clk = 1'b0;
        tick(8);
        release_all();
        tick(4);
    endtask

    task automatic test_saturate();
        logic [31:0] w;
        pulse_load();
        read_bits(20, w);
        checks++;
        if (w[19:0] !== 20'hFFFFF) begin
            errors++; $display("FAIL saturate_bits got %h want fffff", w[19:0]);
        end
        checks++;
        if (dut.cnt !== 5'd16) begin
            errors++; $display("FAIL saturate_cnt got %0d want 16", dut.cnt);
        end
    endtask

    task automatic test_abort();
        logic [31:0] w;
        pulse_load();
        read_bits(5, w);
        checks++;
        if (dut.cnt !== 5'd5) begin
            errors++; $display("FAIL abort_cnt5 got %0d want 5", dut.cnt);
        end
        joy1fire1 = 1'b0;
        tick(4);
        joy_load_n = 1'b0;
        tick(4);
        checks++;
        if (dut.cnt !== 5'd0) begin
            errors++; $display("FAIL abort_cnt0 got %0d want 0", dut.cnt);
        end
        tick(4);
        joy_load_n = 1'b1;
        tick(8);
        read_bits(16, w);
        checks++;
        if (w[15:0] !== 16'hFFF7) begin
            errors++; $display("FAIL abort_word got %h want fff7", w[15:0]);
        end
        release_all();
        tick(4);
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] w;
        joy1up = 1'b0;
        tick(4);
        pulse_load();
        read_bits(7, w);
        checks++;
        if (joy_data !== 1'b0) begin
            errors++; $display("FAIL midframe_bit7 got %b want 0", joy_data);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (joy_data !== 1'b1) begin
            errors++; $display("FAIL midframe_rst_data got %b want 1", joy_data);
        end
        checks++;
        if (dut.cnt !== 5'd0) begin
            errors++; $display("FAIL midframe_rst_cnt got %0d want 0", dut.cnt);
        end
        tick(2);
        rst = 1'b0;
        tick(4);
        pulse_load();
        read_bits(16, w);
        checks++;
        if (w[15:0] !== 16'hFF7F) begin
            errors++; $display("FAIL midframe_next_word got %h want ff7f", w[15:0]);
        end
        release_all();
        tick(4);
    endtask

`ifdef JOYENC_DEBOUNCE_EN
    task automatic test_debounce();
        int bad = 0;
        joy1left = 1'b0;
        tick(5);
        joy1left = 1'b1;
        for (int t = 0; t < 20; t++) begin
            tick(1);
            checks++;
            if (dut.ld[5] !== 1'b1) begin
                errors++; bad++;
                if (bad < 4) $display("FAIL debounce_glitch got %b want 1", dut.ld[5]);
            end
        end
        joy1left = 1'b0;
        tick(14);
        checks++;
        if (dut.ld[5] !== 1'b0) begin
            errors++; $display("FAIL debounce_hold got %b want 0", dut.ld[5]);
        end
        joy1left = 1'b1;
        tick(14);
    endtask
`endif

    initial begin
        test_reset();
        test_idle();
        test_frame();
        test_shift_latency();
        test_saturate();
        test_abort();
        test_reset_mid_frame();
`ifdef JOYENC_DEBOUNCE_EN
        test_debounce();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
